// File: rtl/alu_pkg.sv
// Shared ALU encodings: FunSel codes, flag bit positions and the multiplier sequencer state set.
package alu_pkg;

  localparam logic [4:0] FS_PASSA32 = 5'h10;
  localparam logic [4:0] FS_ADD32   = 5'h14;
  localparam logic [4:0] FS_LSL32   = 5'h1B;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_O = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// ALU operand/result bus. The initiator (sequencer) drives FunSel/A/B/WF; the ALU returns Out/Flags.
interface alu_mul_sequencer_if;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [31:0] AluOut;
  logic [3:0]  AluFlags;

  modport master (
    output AluA, AluB, AluFunSel, AluWF,
    input  AluOut, AluFlags
  );

  modport slave (
    input  AluA, AluB, AluFunSel, AluWF,
    output AluOut, AluFlags
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier that uses the datapath ALU for every add and shift.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [15:0]          OpA,
  input  logic [15:0]          OpB,
  alu_mul_sequencer_if.master  alu,
  output logic                 Busy,
  output logic                 Done,
  output logic [31:0]          Product,
  output logic                 Error
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 16;
  localparam int unsigned CW  = 5;

  localparam logic [OPW-1:0] OP_MASK = OPW'((33'd1 << WIDTH) - 33'd1);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ADD   = ADD;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]     state_q,   state_d;
  logic [DW-1:0]  acc_q,     acc_d;
  logic [DW-1:0]  mcand_q,   mcand_d;
  logic [OPW-1:0] mplier_q,  mplier_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [DW-1:0]  product_q, product_d;
  logic           error_q,   error_d;
  logic           add_wf_q,  add_wf_d;

  logic [DW-1:0]  alu_a_c;
  logic [DW-1:0]  alu_b_c;
  logic [4:0]     alu_fun_c;
  logic           alu_wf_c;

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      error_q   <= 1'b0;
      add_wf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      error_q   <= error_d;
      add_wf_q  <= add_wf_d;
    end
  end

  // Next-state, register updates and ALU drive
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    error_d   = error_q;
    add_wf_d  = add_wf_q;
    alu_a_c   = '0;
    alu_b_c   = '0;
    alu_fun_c = FS_PASSA32;
    alu_wf_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          acc_d    = '0;
          mcand_d  = DW'(OpA & OP_MASK);
          mplier_d = OpB & OP_MASK;
          cnt_d    = '0;
          error_d  = 1'b0;
          add_wf_d = 1'b0;
          state_d  = S_ADD;
        end
      end

      S_ADD: begin
        alu_a_c  = acc_q;
        add_wf_d = 1'b0;
        state_d  = S_SHIFT;
        if (mplier_q[0]) begin
          alu_b_c   = mcand_q;
          alu_fun_c = FS_ADD32;
          alu_wf_c  = 1'b1;
          acc_d     = alu.AluOut;
          add_wf_d  = 1'b1;
        end
`ifdef MUL_EARLY_EXIT_EN
        // Nothing left to accumulate: finish now with the current sum
        if (mplier_q == '0) begin
          state_d   = S_DONE;
          product_d = acc_q;
        end
`endif
      end

      S_SHIFT: begin
        alu_a_c   = mcand_q;
        alu_fun_c = FS_LSL32;
        mcand_d   = alu.AluOut;
        mplier_d  = mplier_q >> 1;
        // Flags were written on the edge that ended the ADD cycle
        if (add_wf_q && alu.AluFlags[FLG_C]) begin
          error_d = 1'b1;
        end
        if (cnt_q == LAST) begin
          state_d   = S_DONE;
          product_d = acc_q;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_ADD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign alu.AluA      = alu_a_c;
  assign alu.AluB      = alu_b_c;
  assign alu.AluFunSel = alu_fun_c;
  assign alu.AluWF     = alu_wf_c;

  assign Busy    = (state_q != S_IDLE);
  assign Done    = (state_q == S_DONE);
  assign Product = product_q;
  assign Error   = error_q;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle unsigned shift-and-add multiplier that drives the datapath ALU as its initiator. It issues FunSel/A/B/WF each cycle and consumes ALUOut/FlagsOut on the ALU's result side. The ALU performs every add and shift; this block holds only sequencing state and operand/accumulator registers. It sits beside the ALU in the execute stage, and the control unit uses it for MUL instructions.

Parameters:
WIDTH, 16, operand width in bits (legal range 1..16); product is 2*WIDTH bits, zero-extended to 32.

Ports:
Clock  in  1  system clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  request; sampled only in IDLE
OpA  in  16  multiplicand; bits above WIDTH are ignored
OpB  in  16  multiplier; bits above WIDTH are ignored
AluA  out  32  ALU A operand
AluB  out  32  ALU B operand
AluFunSel  out  5  ALU function select
AluWF  out  1  ALU flag write enable
AluOut  in  32  ALU result (combinational)
AluFlags  in  4  ALU FlagsOut {Z,C,N,O}; bit2 = C
Busy  out  1  high in every non-IDLE state
Done  out  1  one-cycle pulse; Product is valid in this cycle
Product  out  32  result register; holds its value until the next accepted Start
Error  out  1  sticky carry error; cleared by Reset or an accepted Start

Behaviour:
- Reset: state=IDLE; Acc, Mcand, Mplier, cnt, Product=0; Error=0; Busy=0; Done=0.
- Reset has priority over all other events. Reset mid-operation aborts the operation, no Done is issued, and Product is cleared.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - ALU drive: FunSel=0x10 (32-bit pass A), A=0, B=0, WF=0.
  - On Start: Acc=0, Mcand=zext(OpA[WIDTH-1:0]), Mplier=OpB[WIDTH-1:0], cnt=0, Error=0; go to ADD.
- ADD:
  - If Mplier[0]=1: drive A=Acc, B=Mcand, FunSel=0x14 (32-bit add), WF=1; Acc<=AluOut.
  - If Mplier[0]=0: drive FunSel=0x10, A=Acc, WF=0; Acc is unchanged.
  - Next state: SHIFT.
- SHIFT:
  - Drive A=Mcand, FunSel=0x1B (32-bit LSL), WF=0; Mcand<=AluOut.
  - Mplier shifts right by 1 internally.
  - If the previous ADD cycle had WF=1 and AluFlags[2]=1, set Error (the flags register updated on the edge ending ADD).
  - If cnt==WIDTH-1, go to DONE; otherwise cnt++ and go to ADD.
- DONE:
  - Product<=Acc takes effect on the entry edge; Product is written in the same edge as the final transition.
  - Done=1 for this single cycle; next state is IDLE.
- Latency: Start is accepted at edge k; Done is high in the cycle after edge k+2*WIDTH, which is 33 cycles for WIDTH=16.
- Start while Busy (including the DONE cycle) is ignored, with no queuing.
- Carry can never legitimately occur for WIDTH≤16. Error exists as an ALU-interface integrity check.
- AluWF is high only in ADD cycles whose multiplier bit is 1.

Optional Feature:
Macro MUL_EARLY_EXIT_EN.
- Defined: in ADD, if Mplier==0, skip the add. Drive as for bit 0 with WF=0, go directly to DONE, and set Product<=Acc on that edge. For OpB=0, Done is high in the cycle after edge k+1. For OpB=3, Done is high in the cycle after edge k+5.
- Undefined: always perform WIDTH full ADD/SHIFT iterations, with fixed latency.

Decomposition:
- Shared package alu_pkg holds:
  - FunSel constants FS_PASSA32=5'h10, FS_ADD32=5'h14, FS_LSL32=5'h1B.
  - Flag bit indices FLG_Z=3, FLG_C=2, FLG_N=1, FLG_O=0.
  - The state enum {IDLE, ADD, SHIFT, DONE}.
- No sub-module. A single FSM plus registers is the natural partitioning. The bench instantiates the real ALU alongside.

Test Plan:
1. OpA=3, OpB=5 with the real ALU → Done exactly 33 cycles after the Start edge; Product=0x0000000F; Error=0; AluWF pulses in exactly 2 cycles.
2. OpA=0xFFFF, OpB=0xFFFF → Product=0xFFFE0001; Error=0; AluWF high in 16 ADD cycles.
3. OpA=0x1234, OpB=0 → Product=0. Without the macro, Done at 33 cycles. With MUL_EARLY_EXIT_EN, Done in the cycle after edge k+1.
4. Start at k, Reset at k+10 → IDLE next cycle; Busy=0; Product=0; no Done pulse. A fresh Start with 7×6 → Product=0x2A.
5. Start re-asserted at k+5 and in the DONE cycle with different operands → ignored; Product reflects the first operands only.
6. Stub ALU forces AluFlags=4'b0100 after an ADD with WF=1 → Error=1 from the next cycle, sticky through Done; cleared by the next accepted Start.
